ace_req_arbiter: RTL and testbench

Sequencer and arbiter in front of the 3-state ACE coherence FSM (`ace_3state_fsm`: INVALID / UNIQUE_CLEAN / UNIQUE_DIRTY).
- Accepts three competing requesters: local write (AW), local read (AR) and interconnect snoop (AC).
- Presents exactly one transaction at a time to the FSM as a single-cycle valid pulse.
- Waits for any main-memory access the FSM triggers, and runs the snoop-response (CR) handshake.
- Retires each request with a one-cycle grant.

---
 rtl/ace_pkg.sv | 32 +++
 rtl/ace_arb_pick.sv | 36 +++
 rtl/ace_req_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ace_req_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_pkg.sv
// ace_pkg: shared encodings for the ACE request arbiter.
// Line states, grant ids, response bits and arbiter states.
package ace_pkg;

    localparam logic [2:0] INV = 3'b001;
    localparam logic [2:0] UC  = 3'b010;
    localparam logic [2:0] UD  = 3'b100;

    localparam logic [1:0] GID_NONE = 2'b00;
    localparam logic [1:0] GID_RD   = 2'b01;
    localparam logic [1:0] GID_WR   = 2'b10;
    localparam logic [1:0] GID_SN   = 2'b11;

    localparam int CR_PASS_DIRTY = 1;
    localparam int CR_WAS_UNIQUE = 0;

    localparam int PICK_RD = 0;
    localparam int PICK_WR = 1;
    localparam int PICK_SN = 2;

    localparam logic LAST_RD = 1'b0;
    localparam logic LAST_WR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_MEM,
        S_RESP,
        S_DONE
    } arb_state_e;

endpackage

// File: rtl/ace_arb_pick.sv
// ace_arb_pick: one-hot choice among write, read and snoop.
// Snoop first unless a starved local waits; locals alternate.
module ace_arb_pick
    import ace_pkg::*;
(
    input  logic       ar_req,
    input  logic       aw_req,
    input  logic       ac_req,
    input  logic       last_local,
    input  logic       starve,
    output logic [2:0] pick
);

    logic local_req;

    assign local_req = ar_req | aw_req;

    // snoop priority, starvation override, local round-robin
    always_comb begin
        pick = '0;
        if (ac_req && !(starve && local_req)) begin
            pick[PICK_SN] = 1'b1;
        end else if (ar_req && aw_req) begin
            if (last_local == LAST_WR) begin
                pick[PICK_RD] = 1'b1;
            end else begin
                pick[PICK_WR] = 1'b1;
            end
        end else if (ar_req) begin
            pick[PICK_RD] = 1'b1;
        end else if (aw_req) begin
            pick[PICK_WR] = 1'b1;
        end
    end

endmodule

// File: rtl/ace_req_arbiter.sv
// ace_req_arbiter: sequences AW/AR/AC requests into the ACE line FSM,
// one transaction at a time, with memory wait and snoop response.
module ace_req_arbiter
    import ace_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       aw_req,
    input  logic       ar_req,
    input  logic       ac_req,
    input  logic       ac_snoop_in,
    output logic       aw_gnt,
    output logic       ar_gnt,
    output logic       ac_gnt,
    output logic       fsm_awvalid,
    output logic       fsm_arvalid,
    output logic       fsm_acvalid,
    output logic       fsm_acsnoop,
    output logic       fsm_crready,
    input  logic [2:0] line_state,
    input  logic       fsm_write_main_mem,
    input  logic       fsm_read_main_mem,
    input  logic       mem_done,
    output logic       cr_valid,
    input  logic       cr_ready,
    output logic [1:0] cr_resp,
    output logic       busy,
    output logic [1:0] grant_id,
    output logic       err
);

    localparam int TW = $clog2(MEM_TIMEOUT) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(MEM_TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e    state;
    arb_state_e    state_nx;
    logic          snoop_q;
    logic [2:0]    prev_state;
    logic          last_local;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    pick;
    logic [1:0]    pick_id;
    logic          arb_go;
    logic          local_req;
    logic          starve;

    assign local_req = ar_req | aw_req;
    assign starve    = (starve_cnt == STARVE_MAX);
    assign arb_go    = (state == S_IDLE) && (|pick);
    assign busy      = (state != S_IDLE);

    ace_arb_pick u_pick (
        .ar_req     (ar_req),
        .aw_req     (aw_req),
        .ac_req     (ac_req),
        .last_local (last_local),
        .starve     (starve),
        .pick       (pick)
    );

    // translate the one-hot pick into a grant id
    always_comb begin
        pick_id = GID_NONE;
        unique case (1'b1)
            pick[PICK_SN]: pick_id = GID_SN;
            pick[PICK_WR]: pick_id = GID_WR;
            pick[PICK_RD]: pick_id = GID_RD;
            default:       pick_id = GID_NONE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state and per-state output pulses
    always_comb begin
        state_nx    = state;
        fsm_arvalid = 1'b0;
        fsm_awvalid = 1'b0;
        fsm_acvalid = 1'b0;
        fsm_acsnoop = 1'b0;
        fsm_crready = 1'b0;
        cr_valid    = 1'b0;
        cr_resp     = 2'b00;
        ar_gnt      = 1'b0;
        aw_gnt      = 1'b0;
        ac_gnt      = 1'b0;
        err         = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_go) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fsm_arvalid = (grant_id == GID_RD);
                fsm_awvalid = (grant_id == GID_WR);
                fsm_acvalid = (grant_id == GID_SN);
                fsm_acsnoop = (grant_id == GID_SN) && snoop_q;
                if (grant_id == GID_SN) begin
                    state_nx = S_RESP;
                end else if (fsm_read_main_mem || fsm_write_main_mem) begin
                    state_nx = S_WAIT_MEM;
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_WAIT_MEM: begin
                if (mem_done) begin
                    state_nx = S_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err      = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_RESP: begin
                cr_valid = 1'b1;
                cr_resp[CR_PASS_DIRTY] = (prev_state == UD);
                cr_resp[CR_WAS_UNIQUE] = (prev_state != INV);
                if (cr_ready) begin
                    fsm_crready = 1'b1;
                    state_nx    = S_DONE;
                end
            end
            S_DONE: begin
                ar_gnt   = (grant_id == GID_RD);
                aw_gnt   = (grant_id == GID_WR);
                ac_gnt   = (grant_id == GID_SN);
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // grant capture, starvation count and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id   <= GID_NONE;
            snoop_q    <= 1'b0;
            prev_state <= '0;
            last_local <= LAST_WR;
            starve_cnt <= '0;
        end else if (arb_go) begin
            grant_id   <= pick_id;
            snoop_q    <= ac_snoop_in;
            prev_state <= line_state;
            if (pick[PICK_SN]) begin
                if (local_req && (starve_cnt != STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end else if (state == S_DONE) begin
            grant_id <= GID_NONE;
            if (grant_id == GID_RD) begin
                last_local <= LAST_RD;
            end else if (grant_id == GID_WR) begin
                last_local <= LAST_WR;
            end
        end
    end

    // memory wait counter: cleared while issuing, stops at its last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == S_ISSUE) begin
            tmo_cnt <= '0;
        end else if ((state == S_WAIT_MEM) && (tmo_cnt != TMO_LAST)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ace_req_arbiter.sv
// tb_ace_req_arbiter: scoreboard bench with a transaction-level model
// of arbitration order, latency, snoop response and timeout.
module tb_ace_req_arbiter;

    localparam int MEM_TIMEOUT  = 64;
    localparam int STARVE_LIMIT = 4;
    localparam int RD = 1;
    localparam int WR = 2;
    localparam int SN = 3;
    localparam logic [2:0] LS_INV = 3'b001;
    localparam logic [2:0] LS_UC  = 3'b010;
    localparam logic [2:0] LS_UD  = 3'b100;

    logic       clk;
    logic       rst;
    logic       aw_req, ar_req, ac_req, ac_snoop_in;
    logic       aw_gnt, ar_gnt, ac_gnt;
    logic       fsm_awvalid, fsm_arvalid, fsm_acvalid;
    logic       fsm_acsnoop, fsm_crready;
    logic [2:0] line_state;
    logic       fsm_write_main_mem, fsm_read_main_mem;
    logic       mem_done;
    logic       cr_valid, cr_ready;
    logic [1:0] cr_resp;
    logic       busy;
    logic [1:0] grant_id;
    logic       err;

    typedef struct {
        int         gid;
        bit         snp;
        logic [1:0] resp;
        bit         err;
        int         lat;
    } exp_t;

    exp_t sb[$];

    int n_cmp;
    int n_bad;
    int cyc;
    bit abort;
    int m_starve;
    bit m_prefer_rd;

    bit cfg_miss;
    bit cfg_rdmem;
    int cfg_k;
    int cfg_c;
    int mem_cd;
    int cr_cd;

    ace_req_arbiter #(
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .aw_req             (aw_req),
        .ar_req             (ar_req),
        .ac_req             (ac_req),
        .ac_snoop_in        (ac_snoop_in),
        .aw_gnt             (aw_gnt),
        .ar_gnt             (ar_gnt),
        .ac_gnt             (ac_gnt),
        .fsm_awvalid        (fsm_awvalid),
        .fsm_arvalid        (fsm_arvalid),
        .fsm_acvalid        (fsm_acvalid),
        .fsm_acsnoop        (fsm_acsnoop),
        .fsm_crready        (fsm_crready),
        .line_state         (line_state),
        .fsm_write_main_mem (fsm_write_main_mem),
        .fsm_read_main_mem  (fsm_read_main_mem),
        .mem_done           (mem_done),
        .cr_valid           (cr_valid),
        .cr_ready           (cr_ready),
        .cr_resp            (cr_resp),
        .busy               (busy),
        .grant_id           (grant_id),
        .err                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // line FSM stand-in: miss indication alongside the local valid
    assign fsm_read_main_mem =
        (fsm_arvalid | fsm_awvalid) & cfg_miss & cfg_rdmem;
    assign fsm_write_main_mem =
        (fsm_arvalid | fsm_awvalid) & cfg_miss & ~cfg_rdmem;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int outs();
        return int'({aw_gnt, ar_gnt, ac_gnt, fsm_awvalid, fsm_arvalid,
                     fsm_acvalid, fsm_acsnoop, fsm_crready, cr_valid,
                     cr_resp, busy, grant_id, err});
    endfunction

    // memory and snoop-response responder, driven just after each edge
    always begin
        @(posedge clk);
        #1;
        mem_done = 1'b0;
        if (rst) begin
            mem_cd   = 0;
            cr_cd    = 0;
            cr_ready = 1'b0;
        end else begin
            if (mem_cd > 0) begin
                mem_cd--;
                if (mem_cd == 0) mem_done = 1'b1;
            end
            if ((fsm_arvalid || fsm_awvalid) && cfg_miss && cfg_k > 0)
                mem_cd = cfg_k;
            if (!cr_valid) cr_ready = 1'b0;
            if (cr_cd > 0) begin
                cr_cd--;
                if (cr_cd == 0) cr_ready = 1'b1;
            end
            if (fsm_acvalid) begin
                if (cfg_c == 0) cr_ready = 1'b1;
                else cr_cd = cfg_c;
            end
        end
    end

    int  issue_cyc;
    int  err_cyc;
    int  err_seen;
    int  crh;
    bit  inflight;

    // monitor: pops the scoreboard on every retire pulse
    always @(negedge clk) begin : mon
        int   nv;
        int   ng;
        int   kind;
        exp_t e;
        cyc++;
        if (rst) begin
            inflight = 1'b0;
            err_seen = 0;
            crh      = 0;
        end else begin
            nv = int'(fsm_arvalid) + int'(fsm_awvalid) + int'(fsm_acvalid);
            if (nv != 0) begin
                chk("one_fsm_pulse", nv, 1);
                chk("no_pulse_in_flight", int'(inflight), 0);
                kind = fsm_acvalid ? SN : (fsm_awvalid ? WR : RD);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_issue: kind %0d, none expected",
                             kind);
                end else begin
                    e = sb[0];
                    chk("issue_kind", kind, e.gid);
                    chk("issue_grant_id", int'(grant_id), e.gid);
                    if (e.gid == SN)
                        chk("fsm_acsnoop", int'(fsm_acsnoop), int'(e.snp));
                end
                inflight  = 1'b1;
                issue_cyc = cyc;
                err_seen  = 0;
                crh       = 0;
            end
            if (cr_valid && sb.size() > 0 && sb[0].gid == SN)
                chk("cr_resp", int'(cr_resp), int'(sb[0].resp));
            if (fsm_crready) crh++;
            if (err) begin
                err_seen++;
                err_cyc = cyc;
            end
            ng = int'(ar_gnt) + int'(aw_gnt) + int'(ac_gnt);
            if (ng != 0) begin
                chk("one_gnt", ng, 1);
                kind = ac_gnt ? SN : (aw_gnt ? WR : RD);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_gnt: kind %0d, none expected",
                             kind);
                end else begin
                    e = sb.pop_front();
                    chk("gnt_kind", kind, e.gid);
                    chk("gnt_grant_id", int'(grant_id), e.gid);
                    chk("gnt_latency", cyc - issue_cyc, e.lat);
                    chk("err_count", err_seen, int'(e.err));
                    chk("crready_count", crh, (e.gid == SN) ? 1 : 0);
                    if (e.err) chk("err_to_gnt", cyc - err_cyc, 1);
                end
                inflight = 1'b0;
            end
        end
    end

    // reference arbitration: who wins given the requests now held
    task automatic model_pick(output int w);
        bit lp;
        lp = ar_req | aw_req;
        if (ac_req && !(m_starve == STARVE_LIMIT && lp)) begin
            w = SN;
            if (lp && m_starve < STARVE_LIMIT) m_starve++;
        end else begin
            if (ar_req && aw_req) w = m_prefer_rd ? RD : WR;
            else w = ar_req ? RD : WR;
            m_starve    = 0;
            m_prefer_rd = (w == WR);
        end
    endtask

    // one arbitration, entered and left on an idle negedge
    task automatic do_one(input bit r, input bit w, input bit s,
                          input bit snp, input logic [2:0] ls,
                          input bit miss, input bit rdmem,
                          input int k, input int c);
        int   win;
        bit   got;
        exp_t e;
        if (abort) return;
        if (r) ar_req = 1'b1;
        if (w) aw_req = 1'b1;
        if (s && !ac_req) begin
            ac_req      = 1'b1;
            ac_snoop_in = snp;
        end
        line_state = ls;
        cfg_miss   = miss;
        cfg_rdmem  = rdmem;
        cfg_k      = k;
        cfg_c      = c;
        model_pick(win);
        e.gid  = win;
        e.snp  = ac_snoop_in;
        e.resp = {ls == LS_UD, ls != LS_INV};
        e.err  = 1'b0;
        if (win == SN) begin
            e.lat = ((c < 1) ? 1 : c) + 1;
        end else if (!miss) begin
            e.lat = 1;
        end else if (k == 0) begin
            e.lat = MEM_TIMEOUT + 1;
            e.err = 1'b1;
        end else begin
            e.lat = k + 1;
        end
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (ar_gnt || aw_gnt || ac_gnt) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL gnt_timeout: no grant within 200 cycles, want %0d",
                     win);
            abort = 1'b1;
            return;
        end
        if (ar_gnt) ar_req = 1'b0;
        if (aw_gnt) aw_req = 1'b0;
        if (ac_gnt) ac_req = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_grant_id", int'(grant_id), 0);
    endtask

    // reset in the middle of a memory wait abandons the transaction
    task automatic reset_midop();
        int   win;
        exp_t e;
        if (abort) return;
        ar_req     = 1'b1;
        line_state = LS_INV;
        cfg_miss   = 1'b1;
        cfg_rdmem  = 1'b1;
        cfg_k      = 0;
        model_pick(win);
        e.gid  = win;
        e.snp  = 1'b0;
        e.resp = 2'b00;
        e.err  = 1'b1;
        e.lat  = MEM_TIMEOUT + 1;
        sb.push_back(e);
        repeat (5) @(negedge clk);
        chk("busy_before_reset", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("reset_midop_outputs", outs(), 0);
        sb.delete();
        ar_req      = 1'b0;
        m_starve    = 0;
        m_prefer_rd = 1'b1;
        @(negedge clk);
        chk("reset_no_gnt", int'(ar_gnt | aw_gnt | ac_gnt | err), 0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", int'(busy), 0);
    endtask

    function automatic logic [2:0] rand_ls();
        int v;
        v = $urandom_range(0, 2);
        return (v == 0) ? LS_INV : ((v == 1) ? LS_UC : LS_UD);
    endfunction

    initial begin : stim
        bit r, w, s;
        int sel;
        int k;
        rst         = 1'b1;
        aw_req      = 1'b0;
        ar_req      = 1'b0;
        ac_req      = 1'b0;
        ac_snoop_in = 1'b0;
        line_state  = LS_INV;
        mem_done    = 1'b0;
        cr_ready    = 1'b0;
        cfg_miss    = 1'b0;
        cfg_rdmem   = 1'b0;
        cfg_k       = 0;
        cfg_c       = 0;
        m_starve    = 0;
        m_prefer_rd = 1'b1;
        abort       = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // fairness: both locals held, cache hits
        for (int i = 0; i < 4; i++)
            do_one(1, 1, 0, 0, LS_UC, 0, 1, 1, 0);
        // memory read, done five cycles into the wait
        do_one(1, 0, 0, 0, LS_INV, 1, 1, 5, 0);
        // dirty invalidating snoop, response accepted late
        do_one(0, 0, 1, 1, LS_UD, 0, 0, 1, 4);
        // clean snoop with ready pre-asserted
        do_one(0, 0, 1, 0, LS_UC, 0, 0, 1, 0);
        // memory never answers
        do_one(1, 0, 0, 0, LS_INV, 1, 1, 0, 0);
        // memory answers on the timeout cycle itself
        do_one(0, 1, 0, 0, LS_INV, 1, 0, MEM_TIMEOUT, 0);

        reset_midop();

        // starvation: snoop and write both held
        for (int i = 0; i < 7; i++)
            do_one(0, 1, 1, 1'($urandom_range(0, 1)), LS_UC, 0, 0, 1, 0);

        // randomized mix
        for (int i = 0; i < 80; i++) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            if (!(ar_req || aw_req || ac_req || r || w || s)) r = 1'b1;
            sel = $urandom_range(0, 11);
            if (sel == 0) k = 0;
            else if (sel == 1) k = MEM_TIMEOUT;
            else k = $urandom_range(1, 8);
            do_one(r, w, s, 1'($urandom_range(0, 1)), rand_ls(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   k, $urandom_range(0, 4));
        end

        if (!abort) chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: run did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
